// File: rtl/axi_vga_pkg.sv
// Shared VGA stream definitions: default colour widths, sideband layout and
// pixel/beat sizing helpers used by both the packer and the unpacker.
package axi_vga_pkg;

    localparam int unsigned DefRedWidth   = 5;
    localparam int unsigned DefGreenWidth = 6;
    localparam int unsigned DefBlueWidth  = 5;
    localparam int unsigned DefAxiWidth   = 64;

    // Stream sideband carried next to TDATA through the output register.
    typedef struct packed {
        logic tuser;
        logic tlast;
    } axis_side_t;

    // Width of one packed RGB pixel.
    function automatic int unsigned pixel_width(input int unsigned red_w,
                                                input int unsigned green_w,
                                                input int unsigned blue_w);
        return red_w + green_w + blue_w;
    endfunction

    // Whole pixels that fit in one stream beat; zero means the beat is too narrow.
    function automatic int unsigned pixels_per_beat(input int unsigned data_w,
                                                    input int unsigned pxl_w);
        return (pxl_w == 0) ? 0 : data_w / pxl_w;
    endfunction

endpackage

// File: rtl/axi_vga_stream_reg.sv
// Single-entry valid/ready output register. The valid flag and the payload
// come straight from flops, so the downstream valid never depends on ready.
module axi_vga_stream_reg #(
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 ready_o,
    output logic                 valid_o,
    output logic [DataWidth-1:0] data_o,
    input  logic                 ready_i
);

    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q, data_d;

    // The register may be refilled when empty or when its beat leaves this cycle.
    assign ready_o = !valid_q || ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // Load a new beat when offered, otherwise drop the beat once it is taken.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Register state; reset empties the register and clears the payload.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/axi_vga_pixel_packer.sv
// Packs RGB pixels into AXI-Stream beats, lowest slot in the LSBs. A beat is
// closed when it is full or at end of line; TUSER marks a start-of-frame beat.
module axi_vga_pixel_packer
    import axi_vga_pkg::*;
#(
    parameter int unsigned RedWidth     = DefRedWidth,
    parameter int unsigned GreenWidth   = DefGreenWidth,
    parameter int unsigned BlueWidth    = DefBlueWidth,
    parameter int unsigned AXIDataWidth = DefAxiWidth
) (
    input  logic                    pxl_clk,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    pxl_valid_i,
    output logic                    pxl_ready_o,
    input  logic [RedWidth-1:0]     red_i,
    input  logic [GreenWidth-1:0]   green_i,
    input  logic [BlueWidth-1:0]    blue_i,
    input  logic                    sof_i,
    input  logic                    eol_i,
    output logic                    M_AXIS_TVALID,
    input  logic                    M_AXIS_TREADY,
    output logic [AXIDataWidth-1:0] M_AXIS_TDATA,
    output logic                    M_AXIS_TLAST,
    output logic                    M_AXIS_TUSER,
    output logic                    sof_error_o
);

    localparam int unsigned PixelWidth = pixel_width(RedWidth, GreenWidth, BlueWidth);
    localparam int unsigned PPB        = pixels_per_beat(AXIDataWidth, PixelWidth);
    localparam int unsigned SlotW      = (PPB > 1) ? $clog2(PPB) : 1;
    localparam int unsigned RegWidth   = AXIDataWidth + $bits(axis_side_t);
    localparam logic [SlotW-1:0] LastSlot = SlotW'(PPB - 1);

    if (PPB == 0) begin : g_bad_width
        $error("axi_vga_pixel_packer: AXIDataWidth narrower than one pixel");
    end

    logic [SlotW-1:0]        slot_q, slot_d;
    logic [AXIDataWidth-1:0] acc_q, acc_d;
    logic                    sof_q, sof_d;
    logic                    sof_err_q, sof_err_d;

    logic [PixelWidth-1:0]   pixel;
    logic [AXIDataWidth-1:0] pixel_ext;
    logic [31:0]             shamt;
    logic [AXIDataWidth-1:0] word;
    logic                    accept;
    logic                    complete;
    axis_side_t              side;
    logic                    out_ready;
    logic [RegWidth-1:0]     out_data;

    assign pixel       = {red_i, green_i, blue_i};
    assign pixel_ext   = AXIDataWidth'(pixel);
    assign shamt       = 32'(slot_q) * PixelWidth;
    assign word        = acc_q | (pixel_ext << shamt);
    assign pxl_ready_o = enable_i && out_ready;
    assign accept      = pxl_valid_i && pxl_ready_o;

    // Slot/accumulator update, beat completion and misplaced-sof detection.
    always_comb begin
        slot_d     = slot_q;
        acc_d      = acc_q;
        sof_d      = sof_q;
        sof_err_d  = 1'b0;
        complete   = 1'b0;
        side.tlast = eol_i;
        side.tuser = (slot_q == '0) ? sof_i : sof_q;
        if (!enable_i) begin
            slot_d = '0;
            acc_d  = '0;
            sof_d  = 1'b0;
        end else if (accept) begin
            if (slot_q == '0) begin
                sof_d = sof_i;
            end else if (sof_i) begin
                sof_err_d = 1'b1;
            end
            if ((slot_q == LastSlot) || eol_i) begin
                complete = 1'b1;
                slot_d   = '0;
                acc_d    = '0;
                sof_d    = 1'b0;
            end else begin
                slot_d = slot_q + SlotW'(1);
                acc_d  = word;
            end
        end
    end

    // Packing state and the registered sof error pulse.
    always_ff @(posedge pxl_clk or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_q    <= '0;
            acc_q     <= '0;
            sof_q     <= 1'b0;
            sof_err_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            acc_q     <= acc_d;
            sof_q     <= sof_d;
            sof_err_q <= sof_err_d;
        end
    end

    assign sof_error_o = sof_err_q;

    axi_vga_stream_reg #(
        .DataWidth (RegWidth)
    ) u_out_reg (
        .clk_i   (pxl_clk),
        .rst_ni  (rst_ni),
        .load_i  (complete),
        .data_i  ({side, word}),
        .ready_o (out_ready),
        .valid_o (M_AXIS_TVALID),
        .data_o  (out_data),
        .ready_i (M_AXIS_TREADY)
    );

    assign M_AXIS_TDATA = out_data[AXIDataWidth-1:0];
    assign M_AXIS_TLAST = out_data[AXIDataWidth];
    assign M_AXIS_TUSER = out_data[AXIDataWidth+1];

endmodule
